// File: rtl/data_stack.sv
// rtl/data_stack.sv - operand stack feeding the 16-bit ALU, one op per cycle
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] pop_data,
    output logic [PTR_W:0]   depth,
    output logic             empty,
    output logic             full,
    output logic             err_under,
    output logic             err_over,
    input  logic             err_clr
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_BINOP = 3'd3;
    localparam logic [2:0] OP_DUP   = 3'd4;
    localparam logic [2:0] OP_SWAP  = 3'd5;
    localparam logic [2:0] OP_OVER  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [PTR_W:0] DEPTH_MAX = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W:0]   depth_q, depth_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             err_under_q, err_under_d;
    logic             err_over_q, err_over_d;

    logic [PTR_W-1:0] top_idx, tos_idx, nos_idx;
    logic             has1, has2, is_full, accept, under, over;
    logic [WIDTH-1:0] tos, nos;

    // Indices wrap harmlessly when depth is small; has1/has2 guard every use.
    assign top_idx = PTR_W'(depth_q);
    assign tos_idx = PTR_W'(depth_q - 1'b1);
    assign nos_idx = PTR_W'(depth_q - 2'd2);
    assign has1    = (depth_q != '0);
    assign has2    = (depth_q >= 2);
    assign is_full = (depth_q == DEPTH_MAX);
    assign tos     = has1 ? mem_q[tos_idx] : '0;
    assign nos     = has2 ? mem_q[nos_idx] : '0;

    assign op_ready  = !(err_under_q | err_over_q);
    assign accept    = op_valid & op_ready;
    assign alu_a     = nos;
    assign alu_b     = tos;
    assign pop_data  = pop_data_q;
    assign depth     = depth_q;
    assign empty     = !has1;
    assign full      = is_full;
    assign err_under = err_under_q;
    assign err_over  = err_over_q;

    always_comb begin
        under = 1'b0;
        over  = 1'b0;
        case (op)
            OP_POP:                     under = !has1;
            OP_BINOP, OP_SWAP:          under = !has2;
            OP_OVER: begin
                under = !has2;
                over  = has2 && is_full;
            end
            OP_PUSH, OP_DUP:            over  = is_full;
            default: ;
        endcase
    end

    always_comb begin
        mem_d       = mem_q;
        depth_d     = depth_q;
        pop_data_d  = pop_data_q;
        err_under_d = err_under_q;
        err_over_d  = err_over_q;
        if (err_clr && !op_ready) begin
            err_under_d = 1'b0;
            err_over_d  = 1'b0;
        end else if (accept) begin
            if (under) begin
                err_under_d = 1'b1;
            end else if (over) begin
                err_over_d = 1'b1;
            end else begin
                case (op)
                    OP_PUSH: begin
                        mem_d[top_idx] = push_data;
                        depth_d        = depth_q + 1'b1;
                    end
                    OP_POP: begin
                        pop_data_d = tos;
                        depth_d    = depth_q - 1'b1;
                    end
                    OP_BINOP: begin
                        mem_d[nos_idx] = alu_result;
                        depth_d        = depth_q - 1'b1;
                    end
                    OP_DUP: begin
                        mem_d[top_idx] = tos;
                        depth_d        = depth_q + 1'b1;
                    end
                    OP_SWAP: begin
                        mem_d[tos_idx] = nos;
                        mem_d[nos_idx] = tos;
                    end
                    OP_OVER: begin
                        mem_d[top_idx] = nos;
                        depth_d        = depth_q + 1'b1;
                    end
                    OP_CLEAR: depth_d = '0;
                    OP_NOP:   ;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q     <= '0;
            pop_data_q  <= '0;
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            pop_data_q  <= pop_data_d;
            err_under_q <= err_under_d;
            err_over_q  <= err_over_d;
        end
    end

    // Array contents are don't-care after reset, so storage stays unreset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
